// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the single-cycle CPU: opcode constants used by the
// program-counter sequencer, the default program-counter width and the
// sequencer run/halt state encoding.
// Optional feature macro referenced by users of this package: CALL_STACK_EN
// (enables the CALL/RET opcodes in pc_sequencer).
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int PC_W_DEFAULT = 10;

    // Flow-control opcodes, instr[15:10]
    localparam logic [5:0] OP_J    = 6'b000100;
    localparam logic [5:0] OP_JZ   = 6'b000101;
    localparam logic [5:0] OP_JNZ  = 6'b000110;
    localparam logic [5:0] OP_HALT = 6'b000111;  // also the no-write bubble
    localparam logic [5:0] OP_CALL = 6'b001000;
    localparam logic [5:0] OP_RET  = 6'b001001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } seq_state_t;

endpackage

// File: rtl/ret_stack.sv
// ---------------------------------------------------------------------------
// ret_stack
// Synchronous LIFO holding return addresses for CALL/RET.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-low reset; empties the stack
//   push   in   write din on top (ignored when full)
//   pop    in   discard top entry (ignored when empty)
//   din    in   W-bit value to push
//   dout   out  W-bit current top entry (combinational, valid when !empty)
//   full   out  D entries stored
//   empty  out  no entries stored
// ---------------------------------------------------------------------------
module ret_stack #(
    parameter int W = 10,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = (D > 1) ? $clog2(D) : 1;
    localparam int SW = $clog2(D + 1);

    logic [W-1:0]  r_mem [D];
    logic [SW-1:0] r_sp;           // number of stored entries
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_top_idx;

    assign w_wr_idx  = AW'(r_sp);
    assign w_top_idx = AW'(r_sp - SW'(1));
    assign full      = (r_sp == SW'(D));
    assign empty     = (r_sp == '0);
    assign dout      = r_mem[w_top_idx];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sp <= '0;
        end else if (push && !full) begin
            r_sp <= r_sp + SW'(1);
        end else if (pop && !empty) begin
            r_sp <= r_sp - SW'(1);
        end
    end

    // Storage carries no reset: only entries below r_sp are ever read.
    always_ff @(posedge clk) begin
        if (reset && push && !full) begin
            r_mem[w_wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Instruction-fetch / program-counter sequencer for the single-cycle CPU.
// Presents pc to instruction memory, forwards the opcode to the control unit
// and selects the next pc (increment, J, JZ, JNZ, optional CALL/RET). Owns
// the registered zero flag and the IDLE/RUN/HALT state machine.
// Optional feature: define CALL_STACK_EN to enable CALL/RET with a STACK_D
// deep return stack; otherwise those opcodes are illegal.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-low reset
//   start    in   pulse: leave IDLE/HALT, execute from pc 0
//   instr    in   16-bit instruction at address pc
//   s_inc    in   1 = sequential instruction, 0 = flow control
//   wez      in   zero-flag write enable
//   z        in   ALU zero for the current instruction
//   pc       out  instruction address (registered)
//   opcode   out  instr[15:10] in RUN, else the no-write bubble 000111
//   zflag    out  registered zero flag
//   running  out  state is RUN
//   halted   out  state is HALT
//   fault    out  sticky illegal-opcode / stack fault
// ---------------------------------------------------------------------------
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W    = PC_W_DEFAULT,
    parameter int STACK_D = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [15:0]     instr,
    input  logic            s_inc,
    input  logic            wez,
    input  logic            z,
    output logic [PC_W-1:0] pc,
    output logic [5:0]      opcode,
    output logic            zflag,
    output logic            running,
    output logic            halted,
    output logic            fault
);

    seq_state_t      r_state;
    seq_state_t      w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_target;
    logic [5:0]      w_op;
    logic            r_zflag;
    logic            r_fault;
    logic            w_fault_set;
    logic            w_restart;

    assign w_op      = instr[15:10];
    assign w_target  = instr[PC_W-1:0];
    assign w_pc_inc  = r_pc + PC_W'(1);   // wraps naturally at 2^PC_W
    // start only has effect outside RUN; it also clears zflag, fault, stack.
    assign w_restart = (r_state != ST_RUN) && start;

`ifdef CALL_STACK_EN
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [PC_W-1:0] w_stack_top;

    ret_stack #(
        .W (PC_W),
        .D (STACK_D)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset && !w_restart),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_pc_inc),
        .dout  (w_stack_top),
        .full  (w_full),
        .empty (w_empty)
    );
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_fault_set = 1'b0;
`ifdef CALL_STACK_EN
        w_push      = 1'b0;
        w_pop       = 1'b0;
`endif
        case (r_state)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = '0;
                end
            end
            ST_RUN: begin
                if (s_inc) begin
                    w_pc_nxt = w_pc_inc;
                end else begin
                    case (w_op)
                        OP_J:    w_pc_nxt = w_target;
                        // Branches test the flag registered by an earlier
                        // instruction, not the current z.
                        OP_JZ:   w_pc_nxt = r_zflag  ? w_target : w_pc_inc;
                        OP_JNZ:  w_pc_nxt = !r_zflag ? w_target : w_pc_inc;
                        OP_HALT: w_state_nxt = ST_HALT;
`ifdef CALL_STACK_EN
                        OP_CALL: begin
                            if (w_full) begin
                                w_fault_set = 1'b1;
                                w_state_nxt = ST_HALT;
                            end else begin
                                w_push   = 1'b1;
                                w_pc_nxt = w_target;
                            end
                        end
                        OP_RET: begin
                            if (w_empty) begin
                                w_fault_set = 1'b1;
                                w_state_nxt = ST_HALT;
                            end else begin
                                w_pop    = 1'b1;
                                w_pc_nxt = w_stack_top;
                            end
                        end
`endif
                        default: begin
                            w_fault_set = 1'b1;
                            w_state_nxt = ST_HALT;
                        end
                    endcase
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_zflag <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_restart) begin
                r_zflag <= 1'b0;
            end else if (r_state == ST_RUN && wez) begin
                r_zflag <= z;
            end
            if (w_restart) begin
                r_fault <= 1'b0;
            end else if (w_fault_set) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign pc      = r_pc;
    assign opcode  = (r_state == ST_RUN) ? w_op : OP_HALT;
    assign zflag   = r_zflag;
    assign running = (r_state == ST_RUN);
    assign halted  = (r_state == ST_HALT);
    assign fault   = r_fault;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Directed vector table for the program-flow scenarios, hand-written CALL/RET
// sequences, then randomized instruction streams compared against a
// behavioural model of the sequencer (plain arithmetic and a queue stack).
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int PC_W    = 10;
    localparam int STACK_D = 4;
    localparam logic [15:0] ALU = 16'h4000;  // opcode 010000, sequential

    logic            clk;
    logic            reset;
    logic            start;
    logic [15:0]     instr;
    logic            s_inc;
    logic            wez;
    logic            z;
    logic [PC_W-1:0] pc;
    logic [5:0]      opcode;
    logic            zflag;
    logic            running;
    logic            halted;
    logic            fault;

    pc_sequencer #(
        .PC_W    (PC_W),
        .STACK_D (STACK_D)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .instr   (instr),
        .s_inc   (s_inc),
        .wez     (wez),
        .z       (z),
        .pc      (pc),
        .opcode  (opcode),
        .zflag   (zflag),
        .running (running),
        .halted  (halted),
        .fault   (fault)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // ---------------- vector records ----------------
    typedef struct {
        bit          rst_n;
        bit          start;
        bit          s_inc;
        bit          wez;
        bit          z;
        logic [15:0] instr;
        logic [5:0]  e_op;    // opcode before the edge
        logic [9:0]  e_pc;    // registered outputs after the edge
        bit          e_run;
        bit          e_halt;
        bit          e_z;
        bit          e_fault;
    } vec_t;

    function automatic vec_t mk(bit rn, bit st, bit si, bit we, bit zz,
                                logic [15:0] ins, logic [5:0] eop, logic [9:0] epc,
                                bit er, bit eh, bit ez, bit ef);
        vec_t v;
        v.rst_n = rn; v.start = st; v.s_inc = si; v.wez = we; v.z = zz;
        v.instr = ins; v.e_op = eop; v.e_pc = epc;
        v.e_run = er; v.e_halt = eh; v.e_z = ez; v.e_fault = ef;
        return v;
    endfunction

    // Drive one cycle's inputs just after an edge, check opcode, then check
    // registered outputs just after the following edge.
    task automatic apply(input vec_t v, input string tag);
        reset = v.rst_n; start = v.start; s_inc = v.s_inc;
        wez = v.wez; z = v.z; instr = v.instr;
        #1;
        check({tag, "_opcode"}, int'(opcode), int'(v.e_op));
        @(posedge clk); #1;
        check({tag, "_pc"},      int'(pc),      int'(v.e_pc));
        check({tag, "_running"}, int'(running), int'(v.e_run));
        check({tag, "_halted"},  int'(halted),  int'(v.e_halt));
        check({tag, "_zflag"},   int'(zflag),   int'(v.e_z));
        check({tag, "_fault"},   int'(fault),   int'(v.e_fault));
        start = 1'b0;
    endtask

    // ---------------- behavioural reference model ----------------
    // m_st: 0 idle, 1 run, 2 halt
    int m_st;
    int m_pc;
    bit m_z;
    bit m_f;
    int m_stk[$];

    task automatic model_step(input bit rn, input bit st, input bit si,
                              input bit we, input bit zz, input logic [15:0] ins);
        int op;
        int tgt;
        int nxt;
        bit old_z;
        op  = int'(ins[15:10]);
        tgt = int'(ins[9:0]);
        nxt = (m_pc + 1) % (1 << PC_W);
        if (!rn) begin
            m_st = 0; m_pc = 0; m_z = 0; m_f = 0; m_stk.delete();
            return;
        end
        if (m_st != 1) begin
            if (st) begin
                m_st = 1; m_pc = 0; m_z = 0; m_f = 0; m_stk.delete();
            end
            return;
        end
        old_z = m_z;
        if (we) m_z = zz;
        if (si) begin
            m_pc = nxt;
        end else begin
            case (op)
                4: m_pc = tgt;
                5: m_pc = old_z ? tgt : nxt;
                6: m_pc = old_z ? nxt : tgt;
                7: m_st = 2;
`ifdef CALL_STACK_EN
                8: begin
                    if (m_stk.size() == STACK_D) begin m_f = 1; m_st = 2; end
                    else begin m_stk.push_back(nxt); m_pc = tgt; end
                end
                9: begin
                    if (m_stk.size() == 0) begin m_f = 1; m_st = 2; end
                    else m_pc = m_stk.pop_back();
                end
`endif
                default: begin m_f = 1; m_st = 2; end
            endcase
        end
    endtask

    task automatic rand_cycle(input int idx, input bit force_reset);
        bit          rn, st, si, we, zz;
        int          r;
        int          op;
        logic [15:0] ins;
        int          exp_op;
        rn = force_reset ? 1'b0 : ($urandom_range(0, 79) != 0);
        st = ($urandom_range(0, 3) == 0);
        we = $urandom_range(0, 1);
        zz = $urandom_range(0, 1);
        r  = $urandom_range(0, 99);
        si = 1'b0;
        if (r < 50)      begin op = $urandom_range(16, 63); si = 1'b1; end
        else if (r < 62) op = 4;
        else if (r < 70) op = 5;
        else if (r < 78) op = 6;
        else if (r < 88) op = 8;
        else if (r < 96) op = 9;
        else if (r < 98) op = 7;
        else op = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(10, 15);
        if ($urandom_range(0, 19) == 0) si = 1'b1;  // sequential overrides opcode
        ins = {6'(op), 10'($urandom_range(0, 1023))};

        reset = rn; start = st; s_inc = si; wez = we; z = zz; instr = ins;
        #1;
        exp_op = (m_st == 1) ? op : 7;
        check($sformatf("rnd%0d_opcode", idx), int'(opcode), exp_op);
        model_step(rn, st, si, we, zz, ins);
        @(posedge clk); #1;
        check($sformatf("rnd%0d_pc", idx),      int'(pc),      m_pc);
        check($sformatf("rnd%0d_running", idx), int'(running), int'(m_st == 1));
        check($sformatf("rnd%0d_halted", idx),  int'(halted),  int'(m_st == 2));
        check($sformatf("rnd%0d_zflag", idx),   int'(zflag),   int'(m_z));
        check($sformatf("rnd%0d_fault", idx),   int'(fault),   int'(m_f));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t tbl[$];
        reset = 1'b0; start = 1'b0; instr = ALU; s_inc = 1'b0; wez = 1'b0; z = 1'b0;

        //       rn st si we z  instr     op     pc      run hlt z  f
        tbl.push_back(mk(1, 1, 1, 0, 0, ALU,      6'h07, 10'h000, 1, 0, 0, 0)); // start from IDLE
        tbl.push_back(mk(1, 0, 1, 0, 0, ALU,      6'h10, 10'h001, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, ALU,      6'h10, 10'h002, 1, 0, 0, 0)); // start in RUN ignored
        tbl.push_back(mk(1, 0, 1, 0, 0, ALU,      6'h10, 10'h003, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, ALU,      6'h10, 10'h004, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 1, ALU,      6'h10, 10'h005, 1, 0, 1, 0)); // z=1 latched
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h1420, 6'h05, 10'h020, 1, 0, 1, 0)); // JZ taken
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h1004, 6'h04, 10'h004, 1, 0, 1, 0)); // J 4
        tbl.push_back(mk(1, 0, 1, 1, 0, ALU,      6'h10, 10'h005, 1, 0, 0, 0)); // z=0 latched
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h1420, 6'h05, 10'h006, 1, 0, 0, 0)); // JZ not taken
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h1830, 6'h06, 10'h030, 1, 0, 0, 0)); // JNZ taken
        tbl.push_back(mk(1, 0, 1, 1, 1, ALU,      6'h10, 10'h031, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h1830, 6'h06, 10'h032, 1, 0, 1, 0)); // JNZ not taken
        tbl.push_back(mk(1, 0, 0, 1, 0, 16'h17FF, 6'h05, 10'h3FF, 1, 0, 0, 0)); // JZ uses old flag
        tbl.push_back(mk(1, 0, 1, 0, 0, ALU,      6'h10, 10'h000, 1, 0, 0, 0)); // wrap
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h13FF, 6'h04, 10'h3FF, 1, 0, 0, 0)); // J 3FF
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h1009, 6'h04, 10'h009, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 16'h1C00, 6'h07, 10'h009, 0, 1, 1, 0)); // HALT
        tbl.push_back(mk(1, 0, 1, 0, 0, ALU,      6'h07, 10'h009, 0, 1, 1, 0)); // bubble in HALT
        tbl.push_back(mk(1, 1, 1, 0, 0, ALU,      6'h07, 10'h000, 1, 0, 0, 0)); // restart
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h2800, 6'h0A, 10'h000, 0, 1, 0, 1)); // illegal
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h2800, 6'h07, 10'h000, 0, 1, 0, 1)); // fault sticky
        tbl.push_back(mk(1, 1, 1, 0, 0, ALU,      6'h07, 10'h000, 1, 0, 0, 0)); // start clears fault
        tbl.push_back(mk(1, 0, 1, 1, 1, ALU,      6'h10, 10'h001, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h1015, 6'h04, 10'h015, 1, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, ALU,      6'h10, 10'h000, 0, 0, 0, 0)); // reset mid-run
        tbl.push_back(mk(1, 0, 1, 0, 0, ALU,      6'h07, 10'h000, 0, 0, 0, 0)); // stays IDLE
        tbl.push_back(mk(1, 1, 1, 0, 0, ALU,      6'h07, 10'h000, 1, 0, 0, 0));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc",      int'(pc),      0);
        check("rst_opcode",  int'(opcode),  7);
        check("rst_zflag",   int'(zflag),   0);
        check("rst_running", int'(running), 0);
        check("rst_halted",  int'(halted),  0);
        check("rst_fault",   int'(fault),   0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Running at pc 0 here.
`ifdef CALL_STACK_EN
        apply(mk(1, 0, 0, 0, 0, 16'h1007, 6'h04, 10'h007, 1, 0, 0, 0), "cs_j7");
        apply(mk(1, 0, 0, 0, 0, 16'h2100, 6'h08, 10'h100, 1, 0, 0, 0), "cs_call");
        apply(mk(1, 0, 0, 0, 0, 16'h2400, 6'h09, 10'h008, 1, 0, 0, 0), "cs_ret");
        for (int i = 1; i <= STACK_D; i++) begin
            apply(mk(1, 0, 0, 0, 0, 16'h2000 | 16'(i * 16), 6'h08, 10'(i * 16), 1, 0, 0, 0),
                  $sformatf("cs_nest%0d", i));
        end
        apply(mk(1, 0, 0, 0, 0, 16'h2050, 6'h08, 10'h040, 0, 1, 0, 1), "cs_overflow");
        apply(mk(1, 1, 1, 0, 0, ALU,      6'h07, 10'h000, 1, 0, 0, 0), "cs_restart");
        apply(mk(1, 0, 0, 0, 0, 16'h2400, 6'h09, 10'h000, 0, 1, 0, 1), "cs_underflow");
        apply(mk(1, 1, 1, 0, 0, ALU,      6'h07, 10'h000, 1, 0, 0, 0), "cs_restart2");
`else
        apply(mk(1, 0, 0, 0, 0, 16'h2100, 6'h08, 10'h000, 0, 1, 0, 1), "nocs_call");
        apply(mk(1, 1, 1, 0, 0, ALU,      6'h07, 10'h000, 1, 0, 0, 0), "nocs_restart");
        apply(mk(1, 0, 0, 0, 0, 16'h2400, 6'h09, 10'h000, 0, 1, 0, 1), "nocs_ret");
`endif

        // Randomized phase: first cycle resets so model and DUT align.
        m_st = 0; m_pc = 0; m_z = 0; m_f = 0; m_stk.delete();
        for (int i = 0; i < 600; i++) begin
            rand_cycle(i, i == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-fetch and program-counter sequencer for the single-cycle CPU. It drives the instruction-memory address and sends the 6-bit opcode to the control unit. It takes back the control unit's `s_inc`/`wez` decisions and the ALU zero flag, then selects the next PC: increment, J, JZ, JNZ, or an optional CALL/RET. It owns the registered zero flag and a small run/halt state machine, so the datapath only executes while the sequencer is running.

## Interface
Parameters:
- `PC_W`, 10: program counter / jump target width.
- `STACK_D`, 4: return-stack depth; used only with `CALL_STACK_EN`.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset (sampled on `clk` rising edge).
- `start`  in  1  one-cycle pulse; leaves IDLE or HALT and begins execution at PC 0.
- `instr`  in  16  instruction word from program memory at address `pc` (combinational read).
- `s_inc`  in  1  from control unit; 1 = sequential, 0 = flow-control opcode.
- `wez`  in  1  from control unit; write-enable for the zero flag.
- `z`  in  1  ALU zero output for the current instruction.
- `pc`  out  PC_W  instruction-memory address (registered).
- `opcode`  out  6  to control unit: `instr[15:10]` in RUN, forced to 6'b000111 (no-write bubble) otherwise.
- `zflag`  out  1  registered zero flag.
- `running`  out  1  high in RUN.
- `halted`  out  1  high in HALT.
- `fault`  out  1  sticky; set on illegal opcode or stack over/underflow; cleared by reset or `start`.

## Operation
- Instruction fields: `instr[15:10]` is the opcode; `instr[PC_W-1:0]` is the jump/call target.
- States:
  - IDLE: reset state. On `start`, go to RUN.
  - RUN: executes one instruction per cycle.
  - HALT: reached on the halt opcode 6'b000111, or on any fault.
  - Leaving HALT: `start` returns to RUN with pc=0, zflag=0, stack emptied.
- Next PC in RUN, in priority order:
  1. `s_inc`=1: pc+1, wrapping from 2^PC_W−1 to 0.
  2. `s_inc`=0 with opcode:
     - 000100 J → target.
     - 000101 JZ → target if `zflag` else pc+1.
     - 000110 JNZ → target if `!zflag` else pc+1.
     - 000111 → HALT, pc held.
     - Any other opcode with `s_inc`=0 is illegal: set `fault`, go to HALT, pc held.
- Zero flag: `zflag <= z` at the edge when RUN and `wez`=1. JZ/JNZ test the registered value from an earlier instruction, never the current `z`.
- `start` while RUN is ignored.
- Reset has priority over everything and is effective mid-operation: state IDLE, pc=0, zflag=0, fault=0, stack pointer 0.

## Timing
- Reset values: pc=0, zflag=0, running=0, halted=0, fault=0, opcode=6'b000111.
- Address-to-decode path is combinational (instr→opcode); pc updates one cycle after its instruction is presented.
- Throughput: one instruction per cycle, with zero-cycle branch penalty. Taken jumps land on the next edge.
- `start` in IDLE/HALT: `running`=1 on the following cycle with pc=0, and the instruction at address 0 executes that cycle.
- Entering HALT: `halted` rises one cycle after the halt/illegal instruction; pc still points at that instruction.

## Configuration
- `CALL_STACK_EN`, defined:
  - Opcode 001000 (CALL) pushes pc+1 (wrapped) and jumps to target.
  - Opcode 001001 (RET) pops into pc.
  - Stack is `STACK_D` entries of `PC_W` bits.
  - Push when full, or pop when empty: set `fault`, go to HALT, pc held, stack unchanged.
  - CALL and RET each take one cycle.
- Undefined: 001000/001001 are illegal opcodes (fault + HALT). No stack storage is synthesised.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants (OP_J, OP_JZ, OP_JNZ, OP_HALT, OP_CALL, OP_RET);
  - default `PC_W`;
  - sequencer state enum (ST_IDLE, ST_RUN, ST_HALT).
- One sub-module, `ret_stack`: synchronous LIFO with `push`, `pop`, `din`, `dout`, `full`, `empty`, and the same `clk`/`reset`. Instantiated only under `CALL_STACK_EN`.

## Test plan
- Reset then `start`; program of three ALU ops at 0..2 (s_inc=1) → pc 0,1,2,3 on successive cycles; opcode equals `instr[15:10]`.
- `wez`=1 with z=1 at pc 4, JZ to 0x20 at pc 5 → pc=0x20. Repeat with z=0 → pc=6; JNZ takes the opposite path.
- pc=0x3FF with s_inc=1 → pc=0x000. J to 0x3FF → pc=0x3FF.
- Halt opcode 000111 at pc 9 → halted=1 next cycle, pc stays 9, opcode=000111. Then `start` → pc=0, running=1, zflag=0.
- Assert `reset` low for one cycle while RUN at pc 0x15 → IDLE, pc=0, zflag=0; `start` pulses are ignored only while `reset` is low.
- `CALL_STACK_EN`:
  - CALL 0x100 at pc 7 → pc=0x100; RET → pc=8.
  - Five nested CALLs with STACK_D=4 → fault=1, HALT.
  - Without the macro, CALL → fault=1, HALT.
